ps2_scan_decoder: RTL and testbench
===================================

Name: ps2_scan_decoder

Overview:
- Consumes the byte stream from the PS/2 receiver and parses scan-code set 2 prefixes (E0, F0, E1).
- Emits one key event per complete make/break sequence through a valid/ready holding register.
- Maintains a live modifier/caps-lock vector for downstream keymap or console logic.
- Sits directly downstream of the PS/2 receiver, in the same clock domain.

Parameters:
- PAUSE_LEN, 7: bytes swallowed after E1 before the pause event is emitted.
- FILTER_FAKE_SHIFT, 1: when 1, E0 12 / E0 59 and their breaks are discarded with no event.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset; sampled on rising clk
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- key_code  out  8  scan code of event (prefixes stripped)
- key_ext  out  1  event was E0-prefixed
- key_break  out  1  1=release (F0 seen), 0=press
- key_valid  out  1  event held in output register
- key_ready  in  1  consumer accepts event when key_valid & key_ready
- mods  out  7  [0]LShift [1]RShift [2]LCtrl [3]RCtrl [4]LAlt [5]RAlt [6]CapsLock
- overrun  out  1  sticky; an event was dropped because the holding register was full

Behaviour:
- One clock and one synchronous active-low reset. reset_n=0 at a rising clk forces state IDLE, key_code=0, key_ext=0, key_break=0, key_valid=0, mods=0, overrun=0, pause counter=0. Reset mid-sequence discards any partial prefix.
- The FSM advances only on cycles with rx_valid=1; otherwise it holds.
- IDLE:
  - E0 -> GOT_E0; F0 -> GOT_F0; E1 -> PAUSE with counter=PAUSE_LEN.
  - FA, AA, EE, FE, 00, FF -> discard, stay IDLE.
  - Any other byte -> event(code, ext=0, brk=0), stay IDLE.
- GOT_E0:
  - F0 -> GOT_E0F0; E0 -> stay GOT_E0.
  - Any other byte -> event(code, ext=1, brk=0) -> IDLE.
- GOT_F0:
  - Any byte -> event(code, ext=0, brk=1) -> IDLE.
- GOT_E0F0:
  - Any byte -> event(code, ext=1, brk=1) -> IDLE.
- PAUSE:
  - Each byte decrements the counter without inspecting its value.
  - The byte that brings the counter to 0 generates event(code=8'hE1, ext=0, brk=0) -> IDLE.
- Fake shift: with FILTER_FAKE_SHIFT=1, ext events with code 12 or 59 are suppressed entirely (no event, no mods change).
- Event generation: the event is loaded into the output register on the clock edge that samples the final byte; key_valid rises the following cycle (latency 1 from rx_valid).
- Handshake:
  - key_valid & key_ready at an edge clears key_valid, unless a new event is generated on the same edge, in which case the new event loads and key_valid stays 1.
  - A new event with key_valid=1 & key_ready=0 is dropped; the register keeps the old event and overrun is set until reset.
  - Output fields are stable while key_valid=1 and key_ready=0.
- Modifiers:
  - Updated on every generated event, including dropped ones, so mods always reflect the true key state.
  - Mapping: 12 -> LShift, 59 -> RShift, 14 -> LCtrl, E0 14 -> RCtrl, 11 -> LAlt, E0 11 -> RAlt. Make sets the bit; break clears it.
  - CapsLock (code 58, non-ext): toggles on make only when an internal caps_held flag is 0, then sets caps_held. Break clears caps_held. Typematic repeats therefore do not re-toggle.
  - mods changes on the same edge the event loads.

Decomposition:
- Package ps2_pkg:
  - scan-code constants: E0, E1, F0, FA, AA, EE, FE, and the modifier codes 12, 59, 14, 11, 58;
  - the mods bit-index constants;
  - the FSM state enum (IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE).
- Sub-module ps2_mod_tracker:
  - input: event strobe, code, ext, brk;
  - output: mods;
  - holds caps_held internally.
- The top-level block contains the FSM, pause counter and output holding register.

Test Plan:
- Bytes 1C, then F0 1C, key_ready=1 -> events (1C,ext0,brk0) then (1C,ext0,brk1); each key_valid rises 1 cycle after the final rx_valid; mods=0.
- Bytes E0 75, then E0 F0 75 -> events (75,ext1,brk0) then (75,ext1,brk1).
- Bytes 12, 58, 58, F0 58, 58 -> mods[0]=1; mods[6] goes 1, stays 1 through the repeat, stays 1 after break, then returns to 0 on the next make.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event (E1,ext0,brk0) after the 8th byte; mods unchanged; FSM back in IDLE.
- key_ready=0; bytes 1C then 32 -> key_code holds 1C, overrun=1. Then key_ready=1 and a simultaneous new byte 21 -> 21 loads on the accepting edge and key_valid stays 1.
- E0 sent, then reset_n=0 for one cycle, then 75 -> event (75,ext0,brk0), proving the prefix was cleared. Also E0 12 with the filter on -> no event, mods[0] unchanged. Also AA -> no event.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code set 2 constants, modifier bit positions and decoder FSM states.
package ps2_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MODS_W = 7;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_E1    = 8'hE1;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_FA    = 8'hFA;
  localparam logic [7:0] SC_AA    = 8'hAA;
  localparam logic [7:0] SC_EE    = 8'hEE;
  localparam logic [7:0] SC_FE    = 8'hFE;
  localparam logic [7:0] SC_00    = 8'h00;
  localparam logic [7:0] SC_FF    = 8'hFF;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam int unsigned MOD_LSHIFT = 0;
  localparam int unsigned MOD_RSHIFT = 1;
  localparam int unsigned MOD_LCTRL  = 2;
  localparam int unsigned MOD_RCTRL  = 3;
  localparam int unsigned MOD_LALT   = 4;
  localparam int unsigned MOD_RALT   = 5;
  localparam int unsigned MOD_CAPS   = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GOT_E0   = 3'd1,
    GOT_F0   = 3'd2,
    GOT_E0F0 = 3'd3,
    PAUSE    = 3'd4
  } state_t;

endpackage

// File: rtl/ps2_mod_tracker.sv
// Tracks live modifier and caps-lock state from decoded key events.
module ps2_mod_tracker
  import ps2_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_evt,
  input  logic [BYTE_W-1:0] i_code,
  input  logic              i_ext,
  input  logic              i_brk,
  output logic [MODS_W-1:0] o_mods
);

  logic [MODS_W-1:0] r_mods;
  logic              r_caps_held;

  // Caps toggles once per physical press; typematic repeats are ignored until release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mods      <= '0;
      r_caps_held <= 1'b0;
    end else if (i_evt) begin
      if (!i_ext) begin
        case (i_code)
          SC_LSHIFT: r_mods[MOD_LSHIFT] <= ~i_brk;
          SC_RSHIFT: r_mods[MOD_RSHIFT] <= ~i_brk;
          SC_CTRL:   r_mods[MOD_LCTRL]  <= ~i_brk;
          SC_ALT:    r_mods[MOD_LALT]   <= ~i_brk;
          SC_CAPS: begin
            if (i_brk) begin
              r_caps_held <= 1'b0;
            end else begin
              if (!r_caps_held) r_mods[MOD_CAPS] <= ~r_mods[MOD_CAPS];
              r_caps_held <= 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        case (i_code)
          SC_CTRL: r_mods[MOD_RCTRL] <= ~i_brk;
          SC_ALT:  r_mods[MOD_RALT]  <= ~i_brk;
          default: ;
        endcase
      end
    end
  end

  assign o_mods = r_mods;

endmodule

// File: rtl/ps2_scan_decoder.sv
// Scan-code set 2 prefix parser with a single-entry valid/ready event register.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned PAUSE_LEN         = 7,
  parameter bit          FILTER_FAKE_SHIFT = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [BYTE_W-1:0] key_code,
  output logic              key_ext,
  output logic              key_break,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [MODS_W-1:0] mods,
  output logic              overrun
);

  localparam int unsigned CNT_W = (PAUSE_LEN < 2) ? 1 : $clog2(PAUSE_LEN + 1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_evt_raw, w_evt, w_fake;
  logic [BYTE_W-1:0] w_code;
  logic              w_ext, w_brk;

  logic [BYTE_W-1:0] r_key_code;
  logic              r_key_ext, r_key_break, r_key_valid, r_overrun;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and event decode; only a valid byte moves the FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_evt_raw   = 1'b0;
    w_code      = rx_data;
    w_ext       = 1'b0;
    w_brk       = 1'b0;
    if (rx_valid) begin
      case (r_state)
        IDLE: begin
          if (rx_data == SC_E0) begin
            w_state_nxt = GOT_E0;
          end else if (rx_data == SC_F0) begin
            w_state_nxt = GOT_F0;
          end else if (rx_data == SC_E1) begin
            w_state_nxt = PAUSE;
            w_cnt_nxt   = CNT_W'(PAUSE_LEN);
          end else if ((rx_data == SC_FA) || (rx_data == SC_AA) || (rx_data == SC_EE) ||
                       (rx_data == SC_FE) || (rx_data == SC_00) || (rx_data == SC_FF)) begin
            w_state_nxt = IDLE;
          end else begin
            w_evt_raw = 1'b1;
          end
        end
        GOT_E0: begin
          if (rx_data == SC_F0) begin
            w_state_nxt = GOT_E0F0;
          end else if (rx_data != SC_E0) begin
            w_evt_raw   = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        GOT_F0: begin
          w_evt_raw   = 1'b1;
          w_brk       = 1'b1;
          w_state_nxt = IDLE;
        end
        GOT_E0F0: begin
          w_evt_raw   = 1'b1;
          w_ext       = 1'b1;
          w_brk       = 1'b1;
          w_state_nxt = IDLE;
        end
        PAUSE: begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1)) begin
            w_cnt_nxt   = '0;
            w_evt_raw   = 1'b1;
            w_code      = SC_E1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_fake = FILTER_FAKE_SHIFT && w_ext && ((w_code == SC_LSHIFT) || (w_code == SC_RSHIFT));
  assign w_evt  = w_evt_raw && !w_fake;

  // Holding register: load when empty or being drained, otherwise drop and flag overrun.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_key_code  <= '0;
      r_key_ext   <= 1'b0;
      r_key_break <= 1'b0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_evt) begin
      if (!r_key_valid || key_ready) begin
        r_key_code  <= w_code;
        r_key_ext   <= w_ext;
        r_key_break <= w_brk;
        r_key_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_key_valid && key_ready) begin
      r_key_valid <= 1'b0;
    end
  end

  ps2_mod_tracker u_mods (
    .clk     (clk),
    .reset_n (reset_n),
    .i_evt   (w_evt),
    .i_code  (w_code),
    .i_ext   (w_ext),
    .i_brk   (w_brk),
    .o_mods  (mods)
  );

  assign key_code  = r_key_code;
  assign key_ext   = r_key_ext;
  assign key_break = r_key_break;
  assign key_valid = r_key_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder; expected values are hand-derived per step.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       key_ready;
  logic [6:0] mods;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  ps2_scan_decoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .mods      (mods),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one byte for exactly one rising edge, returns at next negedge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic chk_evt(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    chk({tag, "_valid"}, 8'(key_valid), 8'h01);
    chk({tag, "_code"},  key_code,       code);
    chk({tag, "_ext"},   8'(key_ext),    8'(ext));
    chk({tag, "_brk"},   8'(key_break),  8'(brk));
  endtask

  logic [7:0] pause_seq [8];

  initial begin
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    reset_n   = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    key_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 8'(key_valid), 8'h00);
    chk("rst_code",  key_code,      8'h00);
    chk("rst_ext",   8'(key_ext),   8'h00);
    chk("rst_brk",   8'(key_break), 8'h00);
    chk("rst_mods",  8'(mods),      8'h00);
    chk("rst_ovr",   8'(overrun),   8'h00);
    reset_n = 1'b1;
    @(negedge clk);

    // Plain make/break
    send(8'h1C);
    chk_evt("make1c", 8'h1C, 1'b0, 1'b0);
    send(8'hF0);
    chk("f0_pending", 8'(key_valid), 8'h00);
    send(8'h1C);
    chk_evt("brk1c", 8'h1C, 1'b0, 1'b1);
    chk("mods_plain", 8'(mods), 8'h00);

    // Extended make/break
    send(8'hE0);
    chk("e0_pending", 8'(key_valid), 8'h00);
    send(8'h75);
    chk_evt("make_e075", 8'h75, 1'b1, 1'b0);
    send(8'hE0);
    send(8'hF0);
    chk("e0f0_pending", 8'(key_valid), 8'h00);
    send(8'h75);
    chk_evt("brk_e075", 8'h75, 1'b1, 1'b1);

    // Shift and caps-lock with typematic repeat
    send(8'h12);
    chk("mods_lshift", 8'(mods), 8'h01);
    send(8'h58);
    chk("mods_caps_on", 8'(mods), 8'h41);
    send(8'h58);
    chk("mods_caps_rpt", 8'(mods), 8'h41);
    send(8'hF0);
    send(8'h58);
    chk_evt("caps_brk", 8'h58, 1'b0, 1'b1);
    chk("mods_caps_brk", 8'(mods), 8'h41);
    send(8'h58);
    chk("mods_caps_off", 8'(mods), 8'h01);
    send(8'hF0);
    send(8'h12);
    chk("mods_lshift_up", 8'(mods), 8'h00);

    // Pause sequence: one event after the eighth byte
    for (int i = 0; i < 7; i++) begin
      send(pause_seq[i]);
      chk($sformatf("pause_quiet%0d", i), 8'(key_valid), 8'h00);
    end
    send(pause_seq[7]);
    chk_evt("pause_evt", 8'hE1, 1'b0, 1'b0);
    chk("pause_mods", 8'(mods), 8'h00);
    send(8'h1C);
    chk_evt("post_pause_idle", 8'h1C, 1'b0, 1'b0);

    // Back-pressure and overrun
    @(negedge clk);
    chk("drained", 8'(key_valid), 8'h00);
    key_ready = 1'b0;
    send(8'h1C);
    chk_evt("bp_first", 8'h1C, 1'b0, 1'b0);
    send(8'h32);
    chk("bp_hold_code", key_code, 8'h1C);
    chk("bp_hold_valid", 8'(key_valid), 8'h01);
    chk("bp_overrun", 8'(overrun), 8'h01);
    key_ready = 1'b1;
    send(8'h21);
    chk_evt("accept_and_load", 8'h21, 1'b0, 1'b0);
    chk("ovr_sticky", 8'(overrun), 8'h01);
    @(negedge clk);
    chk("accept_clear", 8'(key_valid), 8'h00);

    // Reset mid-prefix
    send(8'hE0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst2_ovr", 8'(overrun), 8'h00);
    send(8'h75);
    chk_evt("after_rst", 8'h75, 1'b0, 1'b0);

    // Fake shift filtering, discards, right-hand modifiers
    send(8'h12);
    chk("fs_lshift", 8'(mods), 8'h01);
    send(8'hE0);
    send(8'h12);
    chk("fs_make_none", 8'(key_valid), 8'h00);
    chk("fs_make_mods", 8'(mods), 8'h01);
    send(8'hE0);
    send(8'hF0);
    send(8'h12);
    chk("fs_brk_none", 8'(key_valid), 8'h00);
    chk("fs_brk_mods", 8'(mods), 8'h01);
    send(8'hAA);
    chk("aa_discard", 8'(key_valid), 8'h00);
    send(8'hE0);
    send(8'h14);
    chk_evt("rctrl", 8'h14, 1'b1, 1'b0);
    chk("mods_rctrl", 8'(mods), 8'h09);
    send(8'h11);
    chk("mods_lalt", 8'(mods), 8'h19);
    send(8'hE0);
    send(8'h11);
    chk("mods_ralt", 8'(mods), 8'h39);
    send(8'hE0);
    send(8'hF0);
    send(8'h14);
    chk("mods_rctrl_up", 8'(mods), 8'h31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
